// File: rtl/l2_lookup_stage_pkg.sv
// Shared types, constants and helpers for the L2 tag lookup stage.
package l2_lookup_stage_pkg;

  localparam int unsigned L2_SETS       = 256;
  localparam int unsigned L2_SET_BITS   = 8;
  localparam int unsigned L2_TAG_BITS   = 12;
  localparam int unsigned L2_NUM_PORTS  = 8;
  localparam int unsigned L2_WAY_BITS   = 3;
  localparam int unsigned L2_STATE_BITS = 2;

  typedef logic [L2_SET_BITS-1:0]   l2_set_t;
  typedef logic [L2_TAG_BITS-1:0]   l2_tag_t;
  typedef logic [L2_WAY_BITS-1:0]   l2_way_t;
  typedef logic [L2_STATE_BITS-1:0] state_t;

  localparam state_t INVALID = L2_STATE_BITS'(0);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    READ,
    HOLD
  } fsm_t;

  typedef struct packed {
    logic    hit;
    l2_way_t hit_way;
    state_t  hit_state;
    logic    empty_valid;
    l2_way_t empty_way;
    l2_way_t evict_way;
    l2_tag_t tag;
    l2_set_t set_idx;
  } l2_result_t;

  // Round-robin successor of a way index, modulo the way count.
  function automatic l2_way_t next_way(input l2_way_t w);
    if (32'(w) == L2_NUM_PORTS - 1) return '0;
    return w + l2_way_t'(1);
  endfunction

endpackage

// File: rtl/l2_lookup_stage_if.sv
// Request / result / local-memory signals of the lookup stage.
interface l2_lookup_stage_if;
  import l2_lookup_stage_pkg::*;

  logic                              req_valid;
  logic                              req_ready;
  l2_tag_t                           req_tag;
  l2_set_t                           req_set;
  logic                              flush_start;

  logic                              mem_rd_en;
  logic                              mem_wr_rst;
  logic                              mem_wr_en_evict_way;
  l2_set_t                           mem_set;
  l2_way_t                           mem_wr_data_evict_way;
  l2_tag_t [L2_NUM_PORTS-1:0]        mem_rd_tag;
  state_t  [L2_NUM_PORTS-1:0]        mem_rd_state;
  l2_way_t                           mem_rd_evict_way;

  logic                              res_valid;
  logic                              res_ready;
  logic                              res_hit;
  l2_way_t                           res_hit_way;
  state_t                            res_hit_state;
  logic                              res_empty_valid;
  l2_way_t                           res_empty_way;
  l2_way_t                           res_evict_way;
  l2_tag_t                           res_tag;
  l2_set_t                           res_set;
  logic                              init_done;

  // Lookup stage side.
  modport slave (
    input  req_valid, req_tag, req_set, flush_start,
    input  mem_rd_tag, mem_rd_state, mem_rd_evict_way,
    input  res_ready,
    output req_ready,
    output mem_rd_en, mem_wr_rst, mem_wr_en_evict_way, mem_set, mem_wr_data_evict_way,
    output res_valid, res_hit, res_hit_way, res_hit_state, res_empty_valid,
    output res_empty_way, res_evict_way, res_tag, res_set, init_done
  );

  // Requester / memory side.
  modport master (
    output req_valid, req_tag, req_set, flush_start,
    output mem_rd_tag, mem_rd_state, mem_rd_evict_way,
    output res_ready,
    input  req_ready,
    input  mem_rd_en, mem_wr_rst, mem_wr_en_evict_way, mem_set, mem_wr_data_evict_way,
    input  res_valid, res_hit, res_hit_way, res_hit_state, res_empty_valid,
    input  res_empty_way, res_evict_way, res_tag, res_set, init_done
  );

endinterface

// File: rtl/l2_way_select.sv
// Combinational hit / first-empty way detection across all ways of a set.
module l2_way_select
  import l2_lookup_stage_pkg::*;
(
  input  l2_tag_t                    tag,
  input  l2_tag_t [L2_NUM_PORTS-1:0] way_tag,
  input  state_t  [L2_NUM_PORTS-1:0] way_state,
  output logic                       hit,
  output l2_way_t                    hit_way,
  output logic                       empty_valid,
  output l2_way_t                    empty_way
);

  // Lowest matching valid way wins the hit; lowest INVALID way is the empty slot.
  always_comb begin
    hit         = 1'b0;
    hit_way     = '0;
    empty_valid = 1'b0;
    empty_way   = '0;
    for (int w = 0; w < int'(L2_NUM_PORTS); w++) begin
      if (!hit && way_state[w] != INVALID && way_tag[w] == tag) begin
        hit     = 1'b1;
        hit_way = L2_WAY_BITS'(w);
      end
      if (!empty_valid && way_state[w] == INVALID) begin
        empty_valid = 1'b1;
        empty_way   = L2_WAY_BITS'(w);
      end
    end
  end

endmodule

// File: rtl/l2_lookup_stage.sv
// L2 tag lookup stage: init sweep, single-outstanding lookup, evict pointer advance.
module l2_lookup_stage
  import l2_lookup_stage_pkg::*;
(
  input logic              clk,
  input logic              rst,
  l2_lookup_stage_if.slave bus
);

  fsm_t       state_q, state_d;
  l2_set_t    cnt_q, cnt_d;
  l2_tag_t    tag_q, tag_d;
  l2_set_t    set_q, set_d;
  l2_result_t res_q, res_d;
  logic       res_valid_q, res_valid_d;
  logic       init_done_q, init_done_d;

  logic       req_ready_c;
  logic       rd_en_c;
  logic       wr_rst_c;
  logic       wr_evict_c;
  l2_set_t    mem_set_c;
  l2_way_t    wr_data_c;

  logic       sel_hit;
  l2_way_t    sel_hit_way;
  logic       sel_empty_valid;
  l2_way_t    sel_empty_way;

  l2_way_select u_way_select (
    .tag         (tag_q),
    .way_tag     (bus.mem_rd_tag),
    .way_state   (bus.mem_rd_state),
    .hit         (sel_hit),
    .hit_way     (sel_hit_way),
    .empty_valid (sel_empty_valid),
    .empty_way   (sel_empty_way)
  );

  // Next-state, result capture and memory strobe decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tag_d       = tag_q;
    set_d       = set_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    init_done_d = init_done_q;
    req_ready_c = 1'b0;
    rd_en_c     = 1'b0;
    wr_rst_c    = 1'b0;
    wr_evict_c  = 1'b0;
    mem_set_c   = '0;
    wr_data_c   = '0;

    unique case (state_q)
      INIT: begin
        wr_rst_c  = 1'b1;
        mem_set_c = cnt_q;
        cnt_d     = cnt_q + l2_set_t'(1);
        if (32'(cnt_q) == L2_SETS - 1) begin
          cnt_d       = '0;
          init_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      IDLE: begin
        if (bus.flush_start) begin
          // Flush takes priority over a simultaneous request.
          cnt_d       = '0;
          init_done_d = 1'b0;
          state_d     = INIT;
        end else begin
          req_ready_c = 1'b1;
          if (bus.req_valid) begin
            rd_en_c   = 1'b1;
            mem_set_c = bus.req_set;
            tag_d     = bus.req_tag;
            set_d     = bus.req_set;
            state_d   = READ;
          end
        end
      end
      READ: begin
        res_d.hit         = sel_hit;
        res_d.hit_way     = sel_hit_way;
        res_d.hit_state   = sel_hit ? bus.mem_rd_state[sel_hit_way] : INVALID;
        res_d.empty_valid = sel_empty_valid;
        res_d.empty_way   = sel_empty_way;
        res_d.evict_way   = sel_empty_valid ? sel_empty_way : bus.mem_rd_evict_way;
        res_d.tag         = tag_q;
        res_d.set_idx     = set_q;
        res_valid_d       = 1'b1;
        state_d           = HOLD;
      end
      HOLD: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
          // A full-set miss consumed the victim; rotate the pointer.
          if (!res_q.hit && !res_q.empty_valid) begin
            wr_evict_c = 1'b1;
            mem_set_c  = res_q.set_idx;
            wr_data_c  = next_way(res_q.evict_way);
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      tag_q       <= '0;
      set_q       <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tag_q       <= tag_d;
      set_q       <= set_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      init_done_q <= init_done_d;
    end
  end

  // Strobes decode from the INIT state held during reset, so mask them while rst is high.
  assign bus.req_ready             = req_ready_c & ~rst;
  assign bus.mem_rd_en             = rd_en_c & ~rst;
  assign bus.mem_wr_rst            = wr_rst_c & ~rst;
  assign bus.mem_wr_en_evict_way   = wr_evict_c & ~rst;
  assign bus.mem_set               = rst ? '0 : mem_set_c;
  assign bus.mem_wr_data_evict_way = rst ? '0 : wr_data_c;

  assign bus.res_valid       = res_valid_q;
  assign bus.res_hit         = res_q.hit;
  assign bus.res_hit_way     = res_q.hit_way;
  assign bus.res_hit_state   = res_q.hit_state;
  assign bus.res_empty_valid = res_q.empty_valid;
  assign bus.res_empty_way   = res_q.empty_way;
  assign bus.res_evict_way   = res_q.evict_way;
  assign bus.res_tag         = res_q.tag;
  assign bus.res_set         = res_q.set_idx;
  assign bus.init_done       = init_done_q;

endmodule

// File: tb/tb_l2_lookup_stage.sv
// Scoreboard bench for l2_lookup_stage: directed lookups, flush and reset cases.
module tb_l2_lookup_stage;
  import l2_lookup_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l2_lookup_stage_if bus();

  l2_lookup_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checks      = 0;
  int         errors      = 0;
  int         strobe_viol = 0;
  l2_result_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic l2_result_t res_now();
    l2_result_t r;
    r.hit         = bus.res_hit;
    r.hit_way     = bus.res_hit_way;
    r.hit_state   = bus.res_hit_state;
    r.empty_valid = bus.res_empty_valid;
    r.empty_way   = bus.res_empty_way;
    r.evict_way   = bus.res_evict_way;
    r.tag         = bus.res_tag;
    r.set_idx     = bus.res_set;
    return r;
  endfunction

  // Memory data outside the valid read window: every way hits on the request tag.
  task automatic set_junk(input l2_tag_t tag);
    for (int w = 0; w < int'(L2_NUM_PORTS); w++) begin
      bus.mem_rd_tag[w]   = tag;
      bus.mem_rd_state[w] = 2'd1;
    end
    bus.mem_rd_evict_way = 3'd6;
  endtask

  task automatic base_vec(output l2_tag_t [L2_NUM_PORTS-1:0] t, output state_t [L2_NUM_PORTS-1:0] s);
    for (int w = 0; w < int'(L2_NUM_PORTS); w++) begin
      t[w] = L2_TAG_BITS'(32'h100 + w);
      s[w] = 2'd1;
    end
  endtask

  // Monitor: pops the scoreboard on every result handshake; tracks strobe exclusivity.
  initial begin
    l2_result_t e;
    int         n;
    forever begin
      @(negedge clk);
      if (!rst && bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("result", 64'(res_now()), 64'(e));
        end
      end
      n = int'(bus.mem_rd_en) + int'(bus.mem_wr_rst) + int'(bus.mem_wr_en_evict_way);
      if (n > 1 || (n == 0 && bus.mem_set != '0)) strobe_viol++;
    end
  end

  task automatic sweep(input string name);
    int good = 0;
    for (int i = 0; i < int'(L2_SETS); i++) begin
      @(negedge clk);
      if (bus.mem_wr_rst && bus.mem_set == L2_SET_BITS'(i) && !bus.req_ready &&
          !bus.init_done && !bus.mem_rd_en)
        good++;
    end
    check({name, "_sweep_cycles"}, 64'(good), 64'(L2_SETS));
    @(negedge clk);
    check({name, "_done"}, 64'({bus.init_done, bus.req_ready, bus.mem_wr_rst}), 64'(3'b110));
  endtask

  task automatic lookup(input l2_tag_t tag, input l2_set_t set,
                        input l2_tag_t [L2_NUM_PORTS-1:0] tags,
                        input state_t [L2_NUM_PORTS-1:0] states,
                        input l2_way_t evict, input int delay, input l2_result_t e_res,
                        input logic exp_wr, input l2_way_t exp_wr_data);
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_tag   = tag;
    bus.req_set   = set;
    set_junk(tag);
    exp_q.push_back(e_res);
    @(negedge clk);
    check("req_ready", 64'(bus.req_ready), 64'(1));
    check("rd_strobe", 64'({bus.mem_rd_en, bus.mem_set}), 64'({1'b1, set}));
    @(posedge clk); #1;
    bus.req_valid        = 1'b0;
    bus.mem_rd_tag       = tags;
    bus.mem_rd_state     = states;
    bus.mem_rd_evict_way = evict;
    @(negedge clk);
    check("read_busy", 64'({bus.req_ready, bus.res_valid}), 64'(0));
    @(posedge clk); #1;
    set_junk(tag);
    bus.res_ready = (delay == 0);
    @(negedge clk);
    check("latency", 64'(bus.res_valid), 64'(1));
    for (int i = 0; i < delay; i++) begin
      check("hold_stable", 64'({bus.res_valid, res_now()}), 64'({1'b1, e_res}));
      check("hold_no_ptr", 64'({bus.mem_wr_en_evict_way, bus.req_ready}), 64'(0));
      @(posedge clk); #1;
      if (i == delay - 1) bus.res_ready = 1'b1;
      @(negedge clk);
    end
    if (exp_wr)
      check("ptr_write", 64'({bus.mem_wr_en_evict_way, bus.mem_set, bus.mem_wr_data_evict_way}),
            64'({1'b1, set, exp_wr_data}));
    else
      check("ptr_none", 64'(bus.mem_wr_en_evict_way), 64'(0));
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    @(negedge clk);
    check("after_handshake",
          64'({bus.mem_wr_en_evict_way, bus.res_valid, bus.req_ready}), 64'(3'b001));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    l2_tag_t [L2_NUM_PORTS-1:0] tg;
    state_t  [L2_NUM_PORTS-1:0] st;

    bus.req_valid   = 1'b0;
    bus.req_tag     = '0;
    bus.req_set     = '0;
    bus.flush_start = 1'b0;
    bus.res_ready   = 1'b0;
    set_junk('0);

    // Reset state and the power-up sweep.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 64'({bus.init_done, bus.res_valid, bus.req_ready, bus.mem_wr_rst,
                              bus.mem_rd_en, bus.mem_set}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    sweep("reset");

    // Hit in way 3; way 6 also matches but the lower way wins.
    base_vec(tg, st);
    tg[3] = 12'h1A3; st[3] = 2'd2;
    tg[6] = 12'h1A3; st[6] = 2'd3;
    lookup(12'h1A3, 8'd5, tg, st, 3'd4, 0,
           '{hit:1'b1, hit_way:3'd3, hit_state:2'd2, empty_valid:1'b0, empty_way:3'd0,
             evict_way:3'd4, tag:12'h1A3, set_idx:8'd5}, 1'b0, 3'd0);

    // Miss, ways 2 and 6 INVALID.
    base_vec(tg, st);
    st[2] = INVALID; st[6] = INVALID;
    lookup(12'h055, 8'h10, tg, st, 3'd5, 1,
           '{hit:1'b0, hit_way:3'd0, hit_state:2'd0, empty_valid:1'b1, empty_way:3'd2,
             evict_way:3'd2, tag:12'h055, set_idx:8'h10}, 1'b0, 3'd0);

    // Full-set miss, pointer 7 wraps to 0, result held 4 cycles.
    base_vec(tg, st);
    lookup(12'h300, 8'hFF, tg, st, 3'd7, 4,
           '{hit:1'b0, hit_way:3'd0, hit_state:2'd0, empty_valid:1'b0, empty_way:3'd0,
             evict_way:3'd7, tag:12'h300, set_idx:8'hFF}, 1'b1, 3'd0);

    // Matching tag in an INVALID way is not a hit but is the empty slot.
    base_vec(tg, st);
    tg[1] = 12'h0AA; st[1] = INVALID;
    tg[5] = 12'h0AA; st[5] = 2'd1;
    lookup(12'h0AA, 8'h80, tg, st, 3'd3, 0,
           '{hit:1'b1, hit_way:3'd5, hit_state:2'd1, empty_valid:1'b1, empty_way:3'd1,
             evict_way:3'd1, tag:12'h0AA, set_idx:8'h80}, 1'b0, 3'd0);

    // Full-set miss, pointer 2 advances to 3.
    base_vec(tg, st);
    lookup(12'h222, 8'h21, tg, st, 3'd2, 2,
           '{hit:1'b0, hit_way:3'd0, hit_state:2'd0, empty_valid:1'b0, empty_way:3'd0,
             evict_way:3'd2, tag:12'h222, set_idx:8'h21}, 1'b1, 3'd3);

    // Hit in way 0 at set 0, state 3.
    base_vec(tg, st);
    tg[0] = 12'hFFF; st[0] = 2'd3;
    tg[7] = 12'hFFF; st[7] = 2'd2;
    lookup(12'hFFF, 8'h00, tg, st, 3'd6, 1,
           '{hit:1'b1, hit_way:3'd0, hit_state:2'd3, empty_valid:1'b0, empty_way:3'd0,
             evict_way:3'd6, tag:12'hFFF, set_idx:8'h00}, 1'b0, 3'd0);

    // Flush and request in the same IDLE cycle: flush wins.
    @(posedge clk); #1;
    bus.req_valid   = 1'b1;
    bus.req_tag     = 12'h123;
    bus.req_set     = 8'h42;
    bus.flush_start = 1'b1;
    @(negedge clk);
    check("flush_no_rd", 64'({bus.mem_rd_en, bus.req_ready}), 64'(0));
    @(posedge clk); #1;
    bus.req_valid   = 1'b0;
    bus.flush_start = 1'b0;
    sweep("flush");

    // Lookup after flush.
    base_vec(tg, st);
    st[7] = INVALID;
    lookup(12'h104, 8'h33, tg, st, 3'd0, 0,
           '{hit:1'b1, hit_way:3'd4, hit_state:2'd1, empty_valid:1'b1, empty_way:3'd7,
             evict_way:3'd7, tag:12'h104, set_idx:8'h33}, 1'b0, 3'd0);

    // Reset while a result is held.
    base_vec(tg, st);
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_tag   = 12'h077;
    bus.req_set   = 8'h44;
    @(posedge clk); #1;
    bus.req_valid        = 1'b0;
    bus.mem_rd_tag       = tg;
    bus.mem_rd_state     = st;
    bus.mem_rd_evict_way = 3'd5;
    @(posedge clk); #1;
    set_junk(12'h077);
    @(negedge clk);
    check("pre_reset_valid", 64'({bus.res_valid, bus.res_tag, bus.res_evict_way}),
          64'({1'b1, 12'h077, 3'd5}));
    #2;
    rst = 1'b1;
    #1;
    check("async_clear", 64'({bus.res_valid, bus.res_hit, bus.res_evict_way, bus.res_tag,
                              bus.res_set, bus.init_done}), 64'(0));
    check("async_strobes", 64'({bus.mem_rd_en, bus.mem_wr_rst, bus.mem_wr_en_evict_way,
                                bus.mem_set, bus.req_ready}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    sweep("hold_reset");

    // Normal operation after reset recovery.
    base_vec(tg, st);
    lookup(12'h7E0, 8'h99, tg, st, 3'd1, 1,
           '{hit:1'b0, hit_way:3'd0, hit_state:2'd0, empty_valid:1'b0, empty_way:3'd0,
             evict_way:3'd1, tag:12'h7E0, set_idx:8'h99}, 1'b1, 3'd2);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    check("strobe_exclusive", 64'(strobe_viol), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_lookup_stage.md
L2_LOOKUP_STAGE -- requirements
Module: l2_lookup_stage

Interface
REQ-001 SHALL take params/constants from the shared package: L2_SETS, L2_SET_BITS, L2_TAG_BITS, L2_NUM_PORTS, L2_WAY_BITS, INVALID (state code 0).
REQ-002 clk  in  1  sole clock; all flops rising-edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  lookup request valid.
REQ-005 req_ready  out  1  request accepted when req_valid & req_ready.
REQ-006 req_tag  in  l2_tag_t  lookup tag.
REQ-007 req_set  in  l2_set_t  lookup set.
REQ-008 flush_start  in  1  pulse; restarts the full-array invalidation sweep.
REQ-009 mem_rd_en  out  1  read strobe to the local memory.
REQ-010 mem_wr_rst  out  1  invalidate-set strobe to the local memory.
REQ-011 mem_wr_en_evict_way  out  1  evict-way pointer write strobe.
REQ-012 mem_set  out  l2_set_t  set index for any mem_* strobe.
REQ-013 mem_wr_data_evict_way  out  l2_way_t  new evict-way pointer.
REQ-014 mem_rd_tag[L2_NUM_PORTS], mem_rd_state[L2_NUM_PORTS], mem_rd_evict_way  in  per-way tag/state plus pointer; valid exactly one cycle after mem_rd_en.
REQ-015 res_valid / res_ready  out / in  1 each  result handshake.
REQ-016 res_hit, res_hit_way, res_hit_state, res_empty_valid, res_empty_way, res_evict_way, res_tag, res_set  out  result fields, held stable while res_valid & !res_ready.
REQ-017 init_done  out  1  high once the sweep completes; low during any sweep.

Function
REQ-018 FSM states SHALL be INIT, IDLE, READ, HOLD.
REQ-019 INIT: one set per cycle, mem_wr_rst=1, mem_set=counter from 0 to L2_SETS-1; after set L2_SETS-1 -> IDLE, init_done=1; req_ready=0 throughout.
REQ-020 IDLE: req_ready=1; on handshake, mem_rd_en=1 and mem_set=req_set in the same cycle; req_tag/req_set registered; -> READ.
REQ-021 READ: capture the memory outputs into the result register; -> HOLD with res_valid=1 next cycle; request-to-res_valid latency is exactly 2 cycles.
REQ-022 Hit: way w with mem_rd_state[w]!=INVALID and mem_rd_tag[w]==tag; the lowest such w wins; res_hit_state is the state of that way.
REQ-023 Empty: res_empty_valid=1 when any way is INVALID; res_empty_way is the lowest such way.
REQ-024 res_evict_way SHALL be res_empty_way if res_empty_valid, else mem_rd_evict_way.
REQ-025 HOLD: on res_valid & res_ready -> IDLE.
REQ-026 Pointer advance: if the handshaken result has !res_hit & !res_empty_valid, that cycle SHALL drive mem_wr_en_evict_way=1, mem_set=res_set, mem_wr_data_evict_way=res_evict_way+1 mod L2_NUM_PORTS.
REQ-027 One lookup outstanding at most; req_ready=0 in READ, HOLD, INIT.
REQ-028 flush_start SHALL be accepted only in IDLE with no simultaneous req handshake (flush wins; req_ready=0 that cycle): counter=0, -> INIT, init_done=0; ignored in other states.
REQ-029 At most one of mem_rd_en, mem_wr_rst, mem_wr_en_evict_way asserted per cycle; mem_set=0 when none is asserted.

Reset
REQ-030 rst SHALL force state=INIT, counter=0, init_done=0, res_valid=0, all result fields 0, and all mem_* strobes 0 asynchronously; the sweep begins on the first clk edge after rst deasserts.
REQ-031 rst asserted mid-sweep or mid-lookup SHALL abandon the operation; no partial result is ever presented.

Structure
REQ-032 l2_way_t, l2_set_t, l2_tag_t, state_t, and INVALID SHALL live in the shared types/consts package; no local redefinition.
REQ-033 Hit/empty detection SHALL be a combinational sub-module l2_way_select (inputs: tag, per-way tag/state; outputs: hit, hit_way, empty_valid, empty_way).

Verification (L2_SETS=256, L2_NUM_PORTS=8)
REQ-034 Release rst -> mem_wr_rst high for 256 consecutive cycles with mem_set 0..255, then init_done=1 and req_ready=1.
REQ-035 Lookup tag 0x1A3, set 5; memory returns way 3 tag 0x1A3, state non-INVALID -> res_valid 2 cycles later, res_hit=1, res_hit_way=3.
REQ-036 Miss with ways 2 and 6 INVALID -> res_empty_valid=1, res_empty_way=2, res_evict_way=2, no pointer write.
REQ-037 Miss with all ways valid, mem_rd_evict_way=7, res_ready delayed 4 cycles -> fields stable for all 4 cycles; on handshake, a single-cycle mem_wr_en_evict_way with data 0 and mem_set=res_set.
REQ-038 flush_start and req_valid in the same IDLE cycle -> no mem_rd_en, sweep restarts at set 0, init_done=0.
REQ-039 rst asserted in HOLD -> res_valid=0 immediately; a full 256-cycle sweep follows release.
